// File: rtl/rh_intr_pkg.sv
// Shared RH11 definitions: interrupt FSM encodings, default vector and trigger equation.
package rh_intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACKD = 2'd2,
        ST_WREL = 2'd3
    } intr_state_e;

    localparam logic [15:0] RH_INTR_VECT = 16'o000254;

    // Completion edge, attention edge (only while enabled), or software request via CS1 write.
    function automatic logic rh_trigger(
        input logic ie,
        input logic rdy,
        input logic last_rdy,
        input logic ata,
        input logic last_ata,
        input logic write_trig
    );
        return (ie & rdy & ~last_rdy) | (ie & rdy & ata & ~last_ata) | write_trig;
    endfunction

endpackage

// File: rtl/rh_intr.sv
// RH11 interrupt request logic: edge-detected triggers, UBA request/acknowledge
// handshake, and a deferred flag for triggers that land during an acknowledge.
module rh_intr
    import rh_intr_pkg::*;
#(
    parameter logic [15:0] INTR_VECT = RH_INTR_VECT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        rhcs1WRITE,
    input  logic        devLOBYTE,
    input  logic        wrIE,
    input  logic        cs1IE,
    input  logic        cs1RDY,
    input  logic        rpATA,
    input  logic        cs2CLR,
    input  logic        devINTA,
    output logic        devINTR,
    output logic [15:0] devVECT,
    output logic        intrDONE
);

    intr_state_e state_q, state_d;
    logic        deferred_q, deferred_d;
    logic        last_rdy_q, last_rdy_d;
    logic        last_ata_q, last_ata_d;
    logic        intr_q, intr_d;
    logic        done_q, done_d;
    logic [15:0] vect_q, vect_d;

    logic        clear;
    logic        write_trig;
    logic        trigger;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        clear      = devRESET | cs2CLR;
        write_trig = rhcs1WRITE & devLOBYTE & wrIE & cs1RDY;
        trigger    = rh_trigger(cs1IE, cs1RDY, last_rdy_q, rpATA, last_ata_q, write_trig);

        state_d    = state_q;
        deferred_d = deferred_q;
        last_rdy_d = cs1RDY;
        last_ata_d = rpATA;

        if (clear) begin
            // Clears beat any coincident trigger or acknowledge.
            state_d    = ST_IDLE;
            deferred_d = 1'b0;
            last_rdy_d = 1'b0;
            last_ata_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger || deferred_q) begin
                        state_d    = ST_PEND;
                        deferred_d = 1'b0;
                    end
                end
                ST_PEND: begin
                    // Triggers here are absorbed into the request already outstanding.
                    if (devINTA) begin
                        state_d = ST_ACKD;
                    end else if (!cs1IE && !write_trig) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACKD: begin
                    state_d = ST_WREL;
                    if (trigger) begin
                        deferred_d = 1'b1;
                    end
                end
                ST_WREL: begin
                    if (!devINTA) begin
                        state_d = ST_IDLE;
                    end
                    if (trigger) begin
                        deferred_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they are registered alongside it.
        intr_d = (state_d == ST_PEND);
        done_d = (state_d == ST_ACKD);
        vect_d = done_d ? INTR_VECT : 16'h0000;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            deferred_q <= 1'b0;
            last_rdy_q <= 1'b0;
            last_ata_q <= 1'b0;
            intr_q     <= 1'b0;
            done_q     <= 1'b0;
            vect_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            deferred_q <= deferred_d;
            last_rdy_q <= last_rdy_d;
            last_ata_q <= last_ata_d;
            intr_q     <= intr_d;
            done_q     <= done_d;
            vect_q     <= vect_d;
        end
    end

    assign devINTR  = intr_q;
    assign intrDONE = done_q;
    assign devVECT  = vect_q;

endmodule

// File: tb/tb_rh_intr.sv
// Directed self-checking bench for rh_intr: handshake, withdrawal, deferral, clears, async reset.
module tb_rh_intr;

    localparam logic [15:0] EXP_VECT = 16'o000254;

    logic        clk = 1'b0;
    logic        rst;
    logic        devRESET, rhcs1WRITE, devLOBYTE, wrIE, cs1IE, cs1RDY, rpATA, cs2CLR, devINTA;
    logic        devINTR, intrDONE;
    logic [15:0] devVECT;

    int checks = 0;
    int errors = 0;

    rh_intr dut (
        .clk        (clk),
        .rst        (rst),
        .devRESET   (devRESET),
        .rhcs1WRITE (rhcs1WRITE),
        .devLOBYTE  (devLOBYTE),
        .wrIE       (wrIE),
        .cs1IE      (cs1IE),
        .cs1RDY     (cs1RDY),
        .rpATA      (rpATA),
        .cs2CLR     (cs2CLR),
        .devINTA    (devINTA),
        .devINTR    (devINTR),
        .devVECT    (devVECT),
        .intrDONE   (intrDONE)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bring the machine from IDLE to PEND through a cs1RDY 0->1 edge with cs1IE set.
    task automatic go_pend();
        cs1IE = 1'b1; cs1RDY = 1'b0;
        step();
        cs1RDY = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; devRESET = 1'b0; rhcs1WRITE = 1'b0; devLOBYTE = 1'b0; wrIE = 1'b0;
        cs1IE = 1'b1; cs1RDY = 1'b1; rpATA = 1'b0; cs2CLR = 1'b0; devINTA = 1'b0;
        step(); step();
        checks++;
        if ({devINTR, intrDONE, devVECT} !== 18'h0) begin
            errors++; $display("FAIL reset_outputs: intr=%b done=%b vect=%o expected all 0", devINTR, intrDONE, devVECT);
        end
        rst = 1'b0;
        step();
        checks++;
        if (devINTR !== 1'b1) begin
            errors++; $display("FAIL reset_first_trigger: devINTR=%b expected 1", devINTR);
        end
        cs1IE = 1'b0;
        step();
        checks++;
        if (devINTR !== 1'b0) begin
            errors++; $display("FAIL reset_withdraw: devINTR=%b expected 0", devINTR);
        end
    endtask

    task automatic test_completion();
        go_pend();
        checks++;
        if (devINTR !== 1'b1 || intrDONE !== 1'b0 || devVECT !== 16'h0) begin
            errors++; $display("FAIL compl_pend: intr=%b done=%b vect=%o expected 1 0 0", devINTR, intrDONE, devVECT);
        end
        devINTA = 1'b1;
        step();
        checks++;
        if (devINTR !== 1'b0 || intrDONE !== 1'b1 || devVECT !== EXP_VECT) begin
            errors++; $display("FAIL compl_ackd: intr=%b done=%b vect=%o expected 0 1 %o", devINTR, intrDONE, devVECT, EXP_VECT);
        end
        step();
        checks++;
        if (devINTR !== 1'b0 || intrDONE !== 1'b0 || devVECT !== 16'h0) begin
            errors++; $display("FAIL compl_wrel: intr=%b done=%b vect=%o expected 0 0 0", devINTR, intrDONE, devVECT);
        end
        step();
        checks++;
        if (intrDONE !== 1'b0) begin
            errors++; $display("FAIL compl_done_once: intrDONE=%b expected 0", intrDONE);
        end
        devINTA = 1'b0;
        step(); step();
        checks++;
        if (devINTR !== 1'b0) begin
            errors++; $display("FAIL compl_idle: devINTR=%b expected 0", devINTR);
        end
    endtask

    task automatic test_software();
        cs1IE = 1'b0; cs1RDY = 1'b1;
        step();
        rhcs1WRITE = 1'b1; devLOBYTE = 1'b0; wrIE = 1'b1;
        step();
        checks++;
        if (devINTR !== 1'b0) begin
            errors++; $display("FAIL sw_hibyte_write: devINTR=%b expected 0", devINTR);
        end
        devLOBYTE = 1'b1;
        step();
        checks++;
        if (devINTR !== 1'b1) begin
            errors++; $display("FAIL sw_request: devINTR=%b expected 1", devINTR);
        end
        rhcs1WRITE = 1'b0; devLOBYTE = 1'b0; wrIE = 1'b0; cs1IE = 1'b1;
        step();
        checks++;
        if (devINTR !== 1'b1) begin
            errors++; $display("FAIL sw_hold: devINTR=%b expected 1", devINTR);
        end
        devINTA = 1'b1;
        step();
        checks++;
        if (intrDONE !== 1'b1 || devVECT !== EXP_VECT) begin
            errors++; $display("FAIL sw_ack: done=%b vect=%o expected 1 %o", intrDONE, devVECT, EXP_VECT);
        end
        cs1IE = 1'b0;
        step();
        devINTA = 1'b0;
        step();
    endtask

    task automatic test_withdrawal();
        go_pend();
        checks++;
        if (devINTR !== 1'b1) begin
            errors++; $display("FAIL wd_pend: devINTR=%b expected 1", devINTR);
        end
        cs1IE = 1'b0;
        step();
        checks++;
        if (devINTR !== 1'b0 || intrDONE !== 1'b0) begin
            errors++; $display("FAIL wd_drop: intr=%b done=%b expected 0 0", devINTR, intrDONE);
        end
        // A stray acknowledge in IDLE must produce neither a pulse nor a vector.
        devINTA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (intrDONE !== 1'b0 || devVECT !== 16'h0) begin
                errors++; $display("FAIL wd_idle_inta[%0d]: done=%b vect=%o expected 0 0", i, intrDONE, devVECT);
            end
        end
        devINTA = 1'b0;
        step();
    endtask

    task automatic test_absorb();
        rpATA = 1'b0;
        go_pend();
        rpATA = 1'b1;
        step();
        checks++;
        if (devINTR !== 1'b1) begin
            errors++; $display("FAIL absorb_pend: devINTR=%b expected 1", devINTR);
        end
        devINTA = 1'b1;
        step(); step();
        devINTA = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (devINTR !== 1'b0) begin
                errors++; $display("FAIL absorb_no_second[%0d]: devINTR=%b expected 0", i, devINTR);
            end
        end
        rpATA = 1'b0;
        step();
    endtask

    task automatic test_deferred();
        rpATA = 1'b0;
        go_pend();
        devINTA = 1'b1;
        step();
        checks++;
        if (intrDONE !== 1'b1) begin
            errors++; $display("FAIL def_first_ack: intrDONE=%b expected 1", intrDONE);
        end
        step();
        rpATA = 1'b1;
        step();
        checks++;
        if (devINTR !== 1'b0) begin
            errors++; $display("FAIL def_wrel_trig: devINTR=%b expected 0", devINTR);
        end
        devINTA = 1'b0;
        step();
        checks++;
        if (devINTR !== 1'b0) begin
            errors++; $display("FAIL def_exit_wrel: devINTR=%b expected 0", devINTR);
        end
        step();
        checks++;
        if (devINTR !== 1'b1) begin
            errors++; $display("FAIL def_second_req: devINTR=%b expected 1", devINTR);
        end
        devINTA = 1'b1;
        step();
        checks++;
        if (intrDONE !== 1'b1 || devVECT !== EXP_VECT) begin
            errors++; $display("FAIL def_second_ack: done=%b vect=%o expected 1 %o", intrDONE, devVECT, EXP_VECT);
        end
        step();
        devINTA = 1'b0;
        step(); step(); step();
        checks++;
        if (devINTR !== 1'b0) begin
            errors++; $display("FAIL def_cleared: devINTR=%b expected 0", devINTR);
        end
        rpATA = 1'b0;
        step();
    endtask

    task automatic test_clear_priority();
        go_pend();
        cs2CLR = 1'b1; devINTA = 1'b1;
        step();
        checks++;
        if (devINTR !== 1'b0 || intrDONE !== 1'b0 || devVECT !== 16'h0) begin
            errors++; $display("FAIL clr_priority: intr=%b done=%b vect=%o expected 0 0 0", devINTR, intrDONE, devVECT);
        end
        cs2CLR = 1'b0; cs1IE = 1'b0;
        step();
        checks++;
        if (devINTR !== 1'b0 || intrDONE !== 1'b0) begin
            errors++; $display("FAIL clr_after: intr=%b done=%b expected 0 0", devINTR, intrDONE);
        end
        devINTA = 1'b0;
        step();
    endtask

    task automatic test_dev_reset();
        rpATA = 1'b0;
        go_pend();
        devINTA = 1'b1;
        step(); step();
        rpATA = 1'b1;
        step();
        devRESET = 1'b1;
        step();
        checks++;
        if (devINTR !== 1'b0) begin
            errors++; $display("FAIL devreset_idle: devINTR=%b expected 0", devINTR);
        end
        devRESET = 1'b0; devINTA = 1'b0; cs1IE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (devINTR !== 1'b0) begin
                errors++; $display("FAIL devreset_no_deferred[%0d]: devINTR=%b expected 0", i, devINTR);
            end
        end
        rpATA = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        go_pend();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (devINTR !== 1'b0) begin
            errors++; $display("FAIL async_pend: devINTR=%b expected 0", devINTR);
        end
        cs1IE = 1'b0;
        step();
        rst = 1'b0;
        step();
        rpATA = 1'b0;
        go_pend();
        devINTA = 1'b1;
        step(); step();
        rpATA = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({devINTR, intrDONE, devVECT} !== 18'h0) begin
            errors++; $display("FAIL async_wrel: intr=%b done=%b vect=%o expected all 0", devINTR, intrDONE, devVECT);
        end
        cs1IE = 1'b0; devINTA = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (devINTR !== 1'b0) begin
                errors++; $display("FAIL async_no_spurious[%0d]: devINTR=%b expected 0", i, devINTR);
            end
        end
        rpATA = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_completion();
        test_software();
        test_withdrawal();
        test_absorb();
        test_deferred();
        test_clear_priority();
        test_dev_reset();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
